// File: rtl/pm_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : pm_arbiter_pkg
// Brief  : Shared defaults, FSM state and issue-tag types for the PM arbiter.
// Rev    : 1.0
// ---------------------------------------------------------------------------
package pm_arbiter_pkg;

    localparam int ADDR_W_DEFAULT   = 14;
    localparam int DATA_W_DEFAULT   = 16;
    localparam int FAIR_MAX_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD      = 2'd1,
        ST_WR_BUSY = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_IF   = 2'd1,
        TAG_LPM  = 2'd2
    } tag_e;

    // Identifies the owner of the read in flight and, for LPM, which byte.
    typedef struct packed {
        tag_e port;
        logic byte_sel;
    } issue_tag_t;

    function automatic logic [7:0] lpm_byte(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/pm_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : pm_arbiter_if
// Brief  : Requester ports and program-memory port of the PM arbiter.
// Rev    : 1.0
// ---------------------------------------------------------------------------
interface pm_arbiter_if #(
    parameter int ADDR_W = pm_arbiter_pkg::ADDR_W_DEFAULT,
    parameter int DATA_W = pm_arbiter_pkg::DATA_W_DEFAULT
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_data;

    logic              lpm_req;
    logic [ADDR_W:0]   lpm_addr;
    logic              lpm_gnt;
    logic              lpm_valid;
    logic [7:0]        lpm_data;

    logic              spm_req;
    logic [ADDR_W-1:0] spm_addr;
    logic [DATA_W-1:0] spm_data;
    logic              spm_gnt;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, lpm_req, lpm_addr, spm_req, spm_addr, spm_data, mem_dout,
        output if_gnt, if_valid, if_data, lpm_gnt, lpm_valid, lpm_data, spm_gnt,
        output mem_addr, mem_we, mem_din
    );

    // Requesters plus program memory
    modport master (
        output if_req, if_addr, lpm_req, lpm_addr, spm_req, spm_addr, spm_data, mem_dout,
        input  if_gnt, if_valid, if_data, lpm_gnt, lpm_valid, lpm_data, spm_gnt,
        input  mem_addr, mem_we, mem_din
    );

endinterface
`default_nettype wire

// File: rtl/pm_arb_grant.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : pm_arb_grant
// Brief  : SPM > LPM > fetch priority with a fetch-starvation counter.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module pm_arb_grant #(
    parameter int FAIR_MAX = pm_arbiter_pkg::FAIR_MAX_DEFAULT
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  i_en,
    input  wire  i_if_req,
    input  wire  i_lpm_req,
    input  wire  i_spm_req,
    output logic o_if_gnt,
    output logic o_lpm_gnt,
    output logic o_spm_gnt
);

    localparam int c_cnt_w = (FAIR_MAX < 1) ? 1 : $clog2(FAIR_MAX + 1);
    localparam logic [c_cnt_w-1:0] c_fair_max = c_cnt_w'(FAIR_MAX);

    logic [c_cnt_w-1:0] r_fair_cnt;
    logic               w_fair_hit;

    assign w_fair_hit = i_if_req && (r_fair_cnt == c_fair_max);

    // A starved fetch overrides every other requester for one grant.
    always_comb begin
        o_if_gnt  = 1'b0;
        o_lpm_gnt = 1'b0;
        o_spm_gnt = 1'b0;
        if (i_en && !rst) begin
            if (w_fair_hit) begin
                o_if_gnt = 1'b1;
            end else if (i_spm_req) begin
                o_spm_gnt = 1'b1;
            end else if (i_lpm_req) begin
                o_lpm_gnt = 1'b1;
            end else if (i_if_req) begin
                o_if_gnt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fair_cnt <= '0;
        end else if (!i_if_req || o_if_gnt) begin
            r_fair_cnt <= '0;
        end else if (o_lpm_gnt && (r_fair_cnt != c_fair_max)) begin
            r_fair_cnt <= r_fair_cnt + c_cnt_w'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pm_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : pm_arbiter
// Brief  : Shares one synchronous program memory among fetch, LPM and SPM.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module pm_arbiter
    import pm_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEFAULT,
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int FAIR_MAX = FAIR_MAX_DEFAULT
) (
    input wire clk,
    input wire rst,
    pm_arbiter_if.slave bus
);

    state_e            r_state;
    issue_tag_t        r_tag;
    logic [ADDR_W-1:0] r_mem_addr;

    logic              w_if_gnt;
    logic              w_lpm_gnt;
    logic              w_spm_gnt;
    logic              w_any_gnt;
    logic [ADDR_W-1:0] w_mem_addr;

    pm_arb_grant #(
        .FAIR_MAX (FAIR_MAX)
    ) u_grant (
        .clk       (clk),
        .rst       (rst),
        .i_en      (r_state != ST_WR_BUSY),
        .i_if_req  (bus.if_req),
        .i_lpm_req (bus.lpm_req),
        .i_spm_req (bus.spm_req),
        .o_if_gnt  (w_if_gnt),
        .o_lpm_gnt (w_lpm_gnt),
        .o_spm_gnt (w_spm_gnt)
    );

    assign w_any_gnt = w_if_gnt | w_lpm_gnt | w_spm_gnt;

    // The memory address holds its last value between accesses.
    always_comb begin
        w_mem_addr = r_mem_addr;
        if (w_spm_gnt) begin
            w_mem_addr = bus.spm_addr;
        end else if (w_if_gnt) begin
            w_mem_addr = bus.if_addr;
        end else if (w_lpm_gnt) begin
            w_mem_addr = bus.lpm_addr[ADDR_W:1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tag      <= '{port: TAG_NONE, byte_sel: 1'b0};
            r_mem_addr <= '0;
        end else begin
            if (w_any_gnt) begin
                r_mem_addr <= w_mem_addr;
            end
            case (r_state)
                ST_IDLE, ST_RD: begin
                    if (w_spm_gnt) begin
                        r_state <= ST_WR_BUSY;
                        r_tag   <= '{port: TAG_NONE, byte_sel: 1'b0};
                    end else if (w_if_gnt) begin
                        r_state <= ST_RD;
                        r_tag   <= '{port: TAG_IF, byte_sel: 1'b0};
                    end else if (w_lpm_gnt) begin
                        r_state <= ST_RD;
                        r_tag   <= '{port: TAG_LPM, byte_sel: bus.lpm_addr[0]};
                    end else begin
                        r_state <= ST_IDLE;
                        r_tag   <= '{port: TAG_NONE, byte_sel: 1'b0};
                    end
                end
                // The write bubble lets a following read see the new word.
                default: begin
                    r_state <= ST_IDLE;
                    r_tag   <= '{port: TAG_NONE, byte_sel: 1'b0};
                end
            endcase
        end
    end

    assign bus.if_gnt    = w_if_gnt;
    assign bus.lpm_gnt   = w_lpm_gnt;
    assign bus.spm_gnt   = w_spm_gnt;

    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_we    = w_spm_gnt;
    assign bus.mem_din   = w_spm_gnt ? bus.spm_data : '0;

    assign bus.if_valid  = (r_tag.port == TAG_IF);
    assign bus.lpm_valid = (r_tag.port == TAG_LPM);
    assign bus.if_data   = rst ? '0 : bus.mem_dout;
    assign bus.lpm_data  = rst ? '0 : lpm_byte(bus.mem_dout[15:0], r_tag.byte_sel);

endmodule
`default_nettype wire
